// File: rtl/mod_add_pipe.sv
// rtl/mod_add_pipe.sv - pipelined modular adder returning (a + b) mod P on a stream
//
// Purpose:
//   Field-addition unit for the point-arithmetic datapath. Each accepted
//   operand pair (a, b) produces one result (a + b) mod P, in accept order,
//   with the ctl tag carried unchanged alongside the data.
//
// Parameters:
//   BITS     operand/result width
//   P        field modulus (odd, nonzero, < 2^BITS)
//   CTL_BITS sideband tag width
//   LEVEL    pipeline depth in cycles (>= 1)
//
// Ports:
//   clk_i      clock, all state on rising edge
//   rst_ni     asynchronous active-low reset
//   add_dat_i  operand beat: [BITS-1:0] = a, [2*BITS-1:BITS] = b
//   add_ctl_i  sideband tag for the operand beat
//   add_val_i  operand beat valid
//   add_rdy_o  operand beat ready (global pipeline enable)
//   res_dat_o  result (a + b) mod P
//   res_ctl_o  sideband tag of the result
//   res_val_o  result valid
//   res_rdy_i  result ready from the consumer
//   res_sop_o  start of packet, always 1 (single-beat results)
//   res_eop_o  end of packet, always 1
//   res_mod_o  empty-byte count, always 0
//   res_err_o  operand range error flag for this beat
//
// Build option:
//   MOD_ADD_RANGE_CHK_EN  when defined, stage 1 flags a >= P or b >= P and the
//                         flag emerges on res_err_o with that beat; when
//                         undefined no comparator is built and res_err_o is 0.

module mod_add_pipe #(
    parameter int              BITS     = 256,
    parameter logic [BITS-1:0] P        = '0,
    parameter int              CTL_BITS = 8,
    parameter int              LEVEL    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [2*BITS-1:0]   add_dat_i,
    input  logic [CTL_BITS-1:0] add_ctl_i,
    input  logic                add_val_i,
    output logic                add_rdy_o,
    output logic [BITS-1:0]     res_dat_o,
    output logic [CTL_BITS-1:0] res_ctl_o,
    output logic                res_val_o,
    input  logic                res_rdy_i,
    output logic                res_sop_o,
    output logic                res_eop_o,
    output logic                res_mod_o,
    output logic                res_err_o
);

    // Register stages after the select. With LEVEL=1 the select feeds the
    // single output register directly, so there is always at least one.
    localparam int NPOST = (LEVEL > 1) ? LEVEL - 1 : 1;

    logic en;

    // ------------------------------------------------------------------
    // Stage 1: sum and candidate difference, computed in parallel
    // ------------------------------------------------------------------
    logic [BITS-1:0] op_a;
    logic [BITS-1:0] op_b;
    logic [BITS:0]   sum_d;
    logic [BITS-1:0] diff_d;
    logic            ge_d;
    logic            err_d;

    assign op_a  = add_dat_i[BITS-1:0];
    assign op_b  = add_dat_i[2*BITS-1:BITS];
    assign sum_d = {1'b0, op_a} + {1'b0, op_b};

    // Only the low BITS of s - P are ever selected, and those bits are the
    // same whether the subtraction is done wide or modulo 2^BITS. The
    // decision s >= P is taken on the full BITS+1 bit sum instead of the
    // borrow of a wide difference.
    assign diff_d = sum_d[BITS-1:0] - P;
    assign ge_d   = (sum_d >= {1'b0, P});

`ifdef MOD_ADD_RANGE_CHK_EN
    assign err_d = (op_a >= P) || (op_b >= P);
`else
    assign err_d = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Optional register between stage 1 and the select
    // ------------------------------------------------------------------
    logic [BITS-1:0]     sel_s;
    logic [BITS-1:0]     sel_d;
    logic                sel_ge;
    logic                sel_err;
    logic [CTL_BITS-1:0] sel_ctl;
    logic                sel_val;

    generate
        if (LEVEL > 1) begin : g_stage1
            logic [BITS-1:0]     s1_s_q;
            logic [BITS-1:0]     s1_d_q;
            logic                s1_ge_q;
            logic                s1_err_q;
            logic [CTL_BITS-1:0] s1_ctl_q;
            logic                s1_val_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s1_s_q   <= '0;
                    s1_d_q   <= '0;
                    s1_ge_q  <= 1'b0;
                    s1_err_q <= 1'b0;
                    s1_ctl_q <= '0;
                    s1_val_q <= 1'b0;
                end else if (en) begin
                    s1_s_q   <= sum_d[BITS-1:0];
                    s1_d_q   <= diff_d;
                    s1_ge_q  <= ge_d;
                    s1_err_q <= err_d;
                    s1_ctl_q <= add_ctl_i;
                    s1_val_q <= add_val_i;
                end
            end

            assign sel_s   = s1_s_q;
            assign sel_d   = s1_d_q;
            assign sel_ge  = s1_ge_q;
            assign sel_err = s1_err_q;
            assign sel_ctl = s1_ctl_q;
            assign sel_val = s1_val_q;
        end else begin : g_stage1_comb
            assign sel_s   = sum_d[BITS-1:0];
            assign sel_d   = diff_d;
            assign sel_ge  = ge_d;
            assign sel_err = err_d;
            assign sel_ctl = add_ctl_i;
            assign sel_val = add_val_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2 select followed by plain register stages
    // ------------------------------------------------------------------
    logic [BITS-1:0] res_d;

    assign res_d = sel_ge ? sel_d : sel_s;

    logic [BITS-1:0]     res_q [NPOST];
    logic [CTL_BITS-1:0] ctl_q [NPOST];
    logic                err_q [NPOST];
    logic                val_q [NPOST];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NPOST; i++) begin
                res_q[i] <= '0;
                ctl_q[i] <= '0;
                err_q[i] <= 1'b0;
                val_q[i] <= 1'b0;
            end
        end else if (en) begin
            res_q[0] <= res_d;
            ctl_q[0] <= sel_ctl;
            err_q[0] <= sel_err;
            val_q[0] <= sel_val;
            for (int i = 1; i < NPOST; i++) begin
                res_q[i] <= res_q[i-1];
                ctl_q[i] <= ctl_q[i-1];
                err_q[i] <= err_q[i-1];
                val_q[i] <= val_q[i-1];
            end
        end
    end

    // One enable for the whole pipe: it moves whenever the output beat is
    // taken or the output slot is empty. Bubbles inside the pipe are not
    // squeezed out; they simply travel as val=0 stages.
    assign en        = res_rdy_i || !val_q[NPOST-1];
    assign add_rdy_o = en;

    assign res_dat_o = res_q[NPOST-1];
    assign res_ctl_o = ctl_q[NPOST-1];
    assign res_err_o = err_q[NPOST-1];
    assign res_val_o = val_q[NPOST-1];
    assign res_sop_o = 1'b1;
    assign res_eop_o = 1'b1;
    assign res_mod_o = 1'b0;

endmodule

// File: tb/tb_mod_add_pipe.sv
// tb/tb_mod_add_pipe.sv - scoreboard testbench for mod_add_pipe (P=97 and bn128 instances)
module tb_mod_add_pipe;

    localparam int          SB = 8;
    localparam logic [7:0]  SP = 8'd97;
    localparam int          SL = 2;
    localparam int          BB = 256;
    localparam logic [255:0] BP = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam int          BL = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2*SB-1:0] s_in_dat;
    logic [7:0]      s_in_ctl;
    logic            s_in_val, s_in_rdy;
    logic [SB-1:0]   s_out_dat;
    logic [7:0]      s_out_ctl;
    logic            s_out_val, s_out_rdy, s_sop, s_eop, s_mod, s_err;

    logic [2*BB-1:0] b_in_dat;
    logic [7:0]      b_in_ctl;
    logic            b_in_val, b_in_rdy;
    logic [BB-1:0]   b_out_dat;
    logic [7:0]      b_out_ctl;
    logic            b_out_val, b_out_rdy, b_sop, b_eop, b_mod, b_err;

    mod_add_pipe #(.BITS(SB), .P(SP), .CTL_BITS(8), .LEVEL(SL)) u_small (
        .clk_i(clk), .rst_ni(rst_n),
        .add_dat_i(s_in_dat), .add_ctl_i(s_in_ctl), .add_val_i(s_in_val), .add_rdy_o(s_in_rdy),
        .res_dat_o(s_out_dat), .res_ctl_o(s_out_ctl), .res_val_o(s_out_val), .res_rdy_i(s_out_rdy),
        .res_sop_o(s_sop), .res_eop_o(s_eop), .res_mod_o(s_mod), .res_err_o(s_err)
    );

    mod_add_pipe #(.BITS(BB), .P(BP), .CTL_BITS(8), .LEVEL(BL)) u_big (
        .clk_i(clk), .rst_ni(rst_n),
        .add_dat_i(b_in_dat), .add_ctl_i(b_in_ctl), .add_val_i(b_in_val), .add_rdy_o(b_in_rdy),
        .res_dat_o(b_out_dat), .res_ctl_o(b_out_ctl), .res_val_o(b_out_val), .res_rdy_i(b_out_rdy),
        .res_sop_o(b_sop), .res_eop_o(b_eop), .res_mod_o(b_mod), .res_err_o(b_err)
    );

    typedef struct packed {
        logic [255:0] dat;
        logic [7:0]   ctl;
        logic         err;
    } exp_t;

    exp_t sq_s[$];
    exp_t sq_b[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic s_err_exp(input logic [7:0] a, input logic [7:0] b);
`ifdef MOD_ADD_RANGE_CHK_EN
        return (a >= SP) || (b >= SP);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] s_model(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = (int'(a) + int'(b)) % 97;
        return 8'(t);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_out_val !== 1'b0 || s_out_dat !== 8'd0 || s_out_ctl !== 8'd0 || s_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_small got val=%0b dat=%0d ctl=%0d err=%0b exp all 0", s_out_val, s_out_dat, s_out_ctl, s_err);
        end
        checks++;
        if (s_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_small_rdy got %0b exp 1", s_in_rdy);
        end
        checks++;
        if (b_out_val !== 1'b0 || b_out_dat !== 256'd0 || b_out_ctl !== 8'd0 || b_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_big got val=%0b dat=%h ctl=%0d err=%0b exp all 0", b_out_val, b_out_dat, b_out_ctl, b_err);
        end
        checks++;
        if (b_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_big_rdy got %0b exp 1", b_in_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int  n;
        bit  seen;
        @(negedge clk);
        s_out_rdy = 1'b1;
        s_in_dat  = {8'd50, 8'd40};
        s_in_ctl  = 8'd3;
        s_in_val  = 1'b1;
        #1;
        checks++;
        if (s_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL latency_accept got rdy=%0b exp 1", s_in_rdy);
        end
        n = 0;
        seen = 0;
        while (!seen && n < 10) begin
            @(posedge clk);
            n++;
            #1;
            s_in_val = 1'b0;
            if (s_out_val) seen = 1;
        end
        checks++;
        if (!seen || n !== SL) begin
            failures++;
            $display("FAIL latency_cycles got %0d (seen=%0b) exp %0d", n, seen, SL);
        end
        checks++;
        if (s_out_dat !== 8'd90 || s_out_ctl !== 8'd3 || {s_sop, s_eop, s_mod} !== 3'b110 || s_err !== 1'b0) begin
            failures++;
            $display("FAIL latency_result got dat=%0d ctl=%0d sop/eop/mod=%b err=%0b exp 90 3 110 0",
                     s_out_dat, s_out_ctl, {s_sop, s_eop, s_mod}, s_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_out_val !== 1'b0) begin
            failures++;
            $display("FAIL latency_single got val=%0b exp 0 after drain", s_out_val);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [7] = '{8'd40, 8'd60, 8'd96, 8'd0, 8'd96, 8'd5, 8'd97};
        logic [7:0] vb [7] = '{8'd50, 8'd50, 8'd96, 8'd0, 8'd1,  8'd6, 8'd0};
        logic [7:0] ve [7] = '{8'd90, 8'd13, 8'd95, 8'd0, 8'd0,  8'd11, 8'd0};
        int idx = 0;
        int got = 0;
        int cyc = 0;
        exp_t e;
        while ((idx < 7 || got < 7) && cyc < 200) begin
            @(negedge clk);
            s_out_rdy = 1'b1;
            if (idx < 7) begin
                s_in_dat = {vb[idx], va[idx]};
                s_in_ctl = 8'(idx + 3);
                s_in_val = 1'b1;
            end else begin
                s_in_val = 1'b0;
            end
            #1;
            if (s_in_val && s_in_rdy) begin
                e.dat = {248'd0, ve[idx]};
                e.ctl = 8'(idx + 3);
                e.err = s_err_exp(va[idx], vb[idx]);
                sq_s.push_back(e);
                idx++;
            end
            if (s_out_val && s_out_rdy) begin
                checks++;
                if (sq_s.size() == 0) begin
                    failures++;
                    $display("FAIL vec_unexpected got dat=%0d ctl=%0d exp no output", s_out_dat, s_out_ctl);
                end else begin
                    e = sq_s.pop_front();
                    if (s_out_dat !== e.dat[7:0] || s_out_ctl !== e.ctl || s_err !== e.err || {s_sop, s_eop, s_mod} !== 3'b110) begin
                        failures++;
                        $display("FAIL vec_result got dat=%0d ctl=%0d err=%0b exp dat=%0d ctl=%0d err=%0b",
                                 s_out_dat, s_out_ctl, s_err, e.dat[7:0], e.ctl, e.err);
                    end
                    got++;
                end
            end
            cyc++;
        end
        checks++;
        if (got !== 7) begin
            failures++;
            $display("FAIL vec_count got %0d exp 7", got);
        end
    endtask

    task automatic test_backpressure();
        localparam int N = 300;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        bit prev_stall = 0;
        logic [7:0] held_dat, held_ctl;
        logic [7:0] ca, cb;
        exp_t e;
        ca = 8'($urandom_range(0, 96));
        cb = 8'($urandom_range(0, 96));
        while ((idx < N || got < N) && cyc < 4000) begin
            @(negedge clk);
            s_out_rdy = 1'($urandom_range(0, 1));
            if (idx < N) begin
                s_in_dat = {cb, ca};
                s_in_ctl = 8'(idx);
                s_in_val = 1'b1;
            end else begin
                s_in_val = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (s_out_val !== 1'b1 || s_out_dat !== held_dat || s_out_ctl !== held_ctl) begin
                    failures++;
                    $display("FAIL bp_stable got val=%0b dat=%0d ctl=%0d exp 1 %0d %0d",
                             s_out_val, s_out_dat, s_out_ctl, held_dat, held_ctl);
                end
            end
            checks++;
            if (s_in_rdy !== (s_out_rdy || !s_out_val)) begin
                failures++;
                $display("FAIL bp_in_rdy got %0b exp %0b", s_in_rdy, (s_out_rdy || !s_out_val));
            end
            if (s_in_val && s_in_rdy) begin
                e.dat = {248'd0, s_model(ca, cb)};
                e.ctl = 8'(idx);
                e.err = 1'b0;
                sq_s.push_back(e);
                idx++;
                ca = 8'($urandom_range(0, 96));
                cb = 8'($urandom_range(0, 96));
            end
            if (s_out_val && s_out_rdy) begin
                checks++;
                if (sq_s.size() == 0) begin
                    failures++;
                    $display("FAIL bp_unexpected got dat=%0d ctl=%0d exp no output", s_out_dat, s_out_ctl);
                end else begin
                    e = sq_s.pop_front();
                    if (s_out_dat !== e.dat[7:0] || s_out_ctl !== e.ctl || s_err !== e.err) begin
                        failures++;
                        $display("FAIL bp_result got dat=%0d ctl=%0d err=%0b exp dat=%0d ctl=%0d err=%0b",
                                 s_out_dat, s_out_ctl, s_err, e.dat[7:0], e.ctl, e.err);
                    end
                    got++;
                end
            end
            prev_stall = s_out_val && !s_out_rdy;
            held_dat   = s_out_dat;
            held_ctl   = s_out_ctl;
            cyc++;
        end
        checks++;
        if (got !== N) begin
            failures++;
            $display("FAIL bp_count got %0d exp %0d", got, N);
        end
    endtask

    task automatic test_back_to_back(input int n);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int first_cyc = 0;
        int last_cyc = 0;
        logic [255:0] ca, cb;
        logic [256:0] t;
        exp_t e;
        ca = BP - 256'd1;
        cb = BP - 256'd1;
        while ((idx < n || got < n) && cyc < 3 * n + 50) begin
            @(negedge clk);
            b_out_rdy = 1'b1;
            if (idx < n) begin
                b_in_dat = {cb, ca};
                b_in_ctl = 8'(idx);
                b_in_val = 1'b1;
            end else begin
                b_in_val = 1'b0;
            end
            #1;
            if (b_in_val && b_in_rdy) begin
                t = ({1'b0, ca} + {1'b0, cb}) % {1'b0, BP};
                e.dat = t[255:0];
                e.ctl = 8'(idx);
                e.err = 1'b0;
                sq_b.push_back(e);
                idx++;
                if (idx == 1) begin
                    ca = BP - 256'd1;
                    cb = 256'd1;
                end else begin
                    ca = rand256() % BP;
                    cb = rand256() % BP;
                end
            end
            if (b_out_val && b_out_rdy) begin
                checks++;
                if (sq_b.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected got dat=%h ctl=%0d exp no output", b_out_dat, b_out_ctl);
                end else begin
                    e = sq_b.pop_front();
                    if (b_out_dat !== e.dat || b_out_ctl !== e.ctl || b_err !== e.err || {b_sop, b_eop, b_mod} !== 3'b110) begin
                        failures++;
                        $display("FAIL b2b_result got dat=%h ctl=%0d err=%0b exp dat=%h ctl=%0d err=%0b",
                                 b_out_dat, b_out_ctl, b_err, e.dat, e.ctl, e.err);
                    end
                    got++;
                    if (got == 1) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
            cyc++;
        end
        checks++;
        if (got !== n) begin
            failures++;
            $display("FAIL b2b_count got %0d exp %0d", got, n);
        end
        checks++;
        if (last_cyc - first_cyc !== n - 1) begin
            failures++;
            $display("FAIL b2b_throughput got span %0d cycles exp %0d", last_cyc - first_cyc, n - 1);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            checks++;
            if (b_out_val !== 1'b0) begin
                failures++;
                $display("FAIL b2b_extra got val=1 dat=%h exp no further output", b_out_dat);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_out_rdy = 1'b1;
            b_in_dat  = {256'(i + 10), 256'(i + 20)};
            b_in_ctl  = 8'(8'hA0 + i);
            b_in_val  = 1'b1;
        end
        @(negedge clk);
        b_in_val = 1'b0;
        #1;
        checks++;
        if (b_out_val !== 1'b1 || b_out_dat !== 256'd30) begin
            failures++;
            $display("FAIL rst_mid_pre got val=%0b dat=%h exp 1 1e", b_out_val, b_out_dat);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_out_val !== 1'b0 || b_out_dat !== 256'd0 || b_out_ctl !== 8'd0 || b_err !== 1'b0 || b_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_async got val=%0b dat=%h ctl=%0d err=%0b rdy=%0b exp 0 0 0 0 1",
                     b_out_val, b_out_dat, b_out_ctl, b_err, b_in_rdy);
        end
        sq_b.delete();
        sq_s.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_back_to_back(5);
    endtask

    initial begin
        rst_n     = 1'b0;
        s_in_dat  = '0;
        s_in_ctl  = '0;
        s_in_val  = 1'b0;
        s_out_rdy = 1'b0;
        b_in_dat  = '0;
        b_in_ctl  = '0;
        b_in_val  = 1'b0;
        b_out_rdy = 1'b0;
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_back_to_back(1000);
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
